array_sequencer: RTL and testbench
==================================

Name: array_sequencer

Overview:
- Control unit between the host and the SIMD PE array.
- On a start edge it latches one 32-bit instruction, decodes it, and drives it through the phases READ -> EXEC -> WRITE. Operand reads, execution and the register-file write are broadcast to all PEs.
- While the array is idle, it also gives the host a single-PE register read path (PE address + register address -> 16-bit data). Host reads are serialised against instruction execution.

Parameters:
SIZE, 5, PE address width (PEs indexed 0..2^SIZE-1)
LENGTH, 32, instruction width in bits (only 32 is supported)
EX_CYCLES, 2, execute-phase duration in cycles (range 1..15)

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  synchronous, active-high reset
start  in  1  level input; a 0->1 transition launches an instruction
instruction  in  LENGTH  [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:0] funct
host_rd  in  1  host read request, one-cycle pulse
pe_addr  in  SIZE  PE index for the host read
reg_addr  in  10  register address for the host read
pe_rd_data  in  16  read-data bus returned by the selected PE
busy  out  1  instruction in flight
done  out  1  one-cycle pulse at instruction completion
illegal  out  1  one-cycle pulse, coincident with done, when the opcode is unsupported
pe_bcast  out  1  broadcast enable to all PEs
pe_sel  out  SIZE  single-PE select for host reads
rf_raddr_a  out  10  operand A register address
rf_raddr_b  out  10  operand B register address
rf_waddr  out  10  write-back register address
rf_we  out  1  register-file write enable (broadcast)
alu_op  out  6  opcode to the PEs
alu_func  out  6  funct[5:0] to the PEs
rd_valid  out  1  one-cycle pulse: rd_data is valid
rd_data  out  16  host read result

Behaviour:
- Reset (synchronous): state=IDLE, every output 0, pending-read flag cleared, start_q=1. Because start_q resets to 1, holding start high across reset does not launch an instruction.
- Edge detect: start_edge = start & ~start_q. start_q samples start every cycle, in all states.
- IDLE:
  - start_edge -> latch instruction, go to DECODE.
  - Otherwise, host_rd or pending flag set -> latch pe_addr/reg_addr (or use the pending copy), go to HREAD.
  - start_edge has priority over host_rd. A host_rd arriving in the same cycle as start_edge becomes pending.
- DECODE, 1 cycle: busy=1.
  - opcode!=000000 -> go to DONE with the illegal flag set.
  - Otherwise go to READ.
- READ, 1 cycle: busy=1, pe_bcast=1, rf_raddr_a={5'b0,rs}, rf_raddr_b={5'b0,rt}.
- EXEC, EX_CYCLES cycles: busy=1, pe_bcast=1, alu_op and alu_func driven. A 4-bit counter loads EX_CYCLES-1 on entry and decrements; leave when it reaches 0.
- WRITE, 1 cycle: busy=1, pe_bcast=1, rf_waddr={5'b0,rd}. rf_we=1 only if rd!=0 (register 0 is hardwired).
- DONE, 1 cycle: done=1, illegal=flag, busy=0, then go to IDLE.
- Latency:
  - Legal instruction: busy is high for EX_CYCLES+3 cycles, starting the cycle after the start edge is sampled. done follows immediately after.
  - Illegal instruction: busy for 1 cycle, then done+illegal. No pe_bcast and no rf_we are ever asserted.
- Address/control outputs (rf_raddr_*, rf_waddr, alu_*): held at their last values while the phase is active and return to 0 in IDLE/DONE.
- HREAD, 1 cycle: pe_sel=pe_addr, rf_raddr_a=reg_addr.
- HRESP, 1 cycle: rd_data<=pe_rd_data, rd_valid=1, clear pending, go to IDLE. rd_data holds its value until the next read.
- host_rd while not in IDLE: sets the pending flag and stores the address. Only one request is queued; further requests while pending is set are dropped.
- start_edge while not in IDLE: ignored, not queued. Holding start high does not retrigger.
- Reset mid-operation: aborts immediately. No done pulse, pending read discarded, rf_we deasserted in the same cycle.

Test Plan:
- Legal instruction: reset, then instruction=0x00241800 (rs=1, rt=4, rd=3), start 0->1 held high, EX_CYCLES=2 -> busy high 5 cycles; READ shows raddr_a=1, raddr_b=4; one rf_we cycle with waddr=3; one done pulse; no second launch while start stays high.
- rd=0 and illegal opcode: instruction=0x00240000 -> full sequence runs, rf_we never asserted. Opcode 0x08 -> busy 1 cycle, then done=illegal=1, pe_bcast never asserted.
- Idle host read: pe_addr=0x11, reg_addr=0x20, host_rd pulse -> pe_sel=0x11 and raddr_a=0x20 the next cycle; rd_valid with rd_data=pe_rd_data (drive 0xBEEF) two cycles after the request.
- Read during busy: host_rd 1 cycle after launch -> no pe_sel activity until after done; rd_valid 2 cycles after return to IDLE. A second host_rd during the same busy period is dropped.
- Same-cycle contention: start edge and host_rd together -> instruction runs first, read is served afterwards. Assert reset during EXEC -> all outputs 0 the next cycle, no done, no rd_valid.

Source files
------------

// File: rtl/array_sequencer.sv
// rtl/array_sequencer.sv - SIMD PE array instruction sequencer with serialised host register reads
module array_sequencer #(
    parameter int SIZE      = 5,
    parameter int LENGTH    = 32,
    parameter int EX_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LENGTH-1:0] instruction,
    input  logic              host_rd,
    input  logic [SIZE-1:0]   pe_addr,
    input  logic [9:0]        reg_addr,
    input  logic [15:0]       pe_rd_data,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic              pe_bcast,
    output logic [SIZE-1:0]   pe_sel,
    output logic [9:0]        rf_raddr_a,
    output logic [9:0]        rf_raddr_b,
    output logic [9:0]        rf_waddr,
    output logic              rf_we,
    output logic [5:0]        alu_op,
    output logic [5:0]        alu_func,
    output logic              rd_valid,
    output logic [15:0]       rd_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_READ, S_EXEC, S_WRITE, S_DONE, S_HREAD, S_HRESP
    } state_t;

    state_t          state_q, state_d;
    logic            start_q, start_d;
    logic [5:0]      op_q, op_d;
    logic [4:0]      rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [5:0]      func_q, func_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [SIZE-1:0] pend_pe_q, pend_pe_d, hr_pe_q, hr_pe_d;
    logic [9:0]      pend_reg_q, pend_reg_d, hr_reg_q, hr_reg_d;
    logic [15:0]     rd_data_q, rd_data_d;
    logic            start_edge;
    logic            unused_bits;

    assign unused_bits = ^instruction[10:6];
    assign start_edge  = start & ~start_q;

    always_comb begin
        state_d    = state_q;
        start_d    = start;
        op_d       = op_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        func_d     = func_q;
        illegal_d  = illegal_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_pe_d  = pend_pe_q;
        pend_reg_d = pend_reg_q;
        hr_pe_d    = hr_pe_q;
        hr_reg_d   = hr_reg_q;
        rd_data_d  = rd_data_q;

        // Any request that cannot be served right now is queued, one deep.
        if (host_rd && !pend_q && !(state_q == S_IDLE && !start_edge)) begin
            pend_d     = 1'b1;
            pend_pe_d  = pe_addr;
            pend_reg_d = reg_addr;
        end

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    op_d      = instruction[31:26];
                    rs_d      = instruction[25:21];
                    rt_d      = instruction[20:16];
                    rd_d      = instruction[15:11];
                    func_d    = instruction[5:0];
                    illegal_d = 1'b0;
                    state_d   = S_DECODE;
                end else if (pend_q) begin
                    hr_pe_d  = pend_pe_q;
                    hr_reg_d = pend_reg_q;
                    pend_d   = 1'b0;
                    state_d  = S_HREAD;
                end else if (host_rd) begin
                    hr_pe_d  = pe_addr;
                    hr_reg_d = reg_addr;
                    state_d  = S_HREAD;
                end
            end
            S_DECODE: begin
                if (op_q != 6'd0) begin
                    illegal_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                cnt_d   = 4'(EX_CYCLES - 1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) state_d = S_WRITE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            // The selected PE presents its register during HREAD; capture it so it is stable with rd_valid.
            S_HREAD: begin
                rd_data_d = pe_rd_data;
                state_d   = S_HRESP;
            end
            S_HRESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b1;
            op_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            func_q     <= '0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_pe_q  <= '0;
            pend_reg_q <= '0;
            hr_pe_q    <= '0;
            hr_reg_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            op_q       <= op_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            func_q     <= func_d;
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_pe_q  <= pend_pe_d;
            pend_reg_q <= pend_reg_d;
            hr_pe_q    <= hr_pe_d;
            hr_reg_q   <= hr_reg_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;
        pe_bcast   = 1'b0;
        pe_sel     = '0;
        rf_raddr_a = '0;
        rf_raddr_b = '0;
        rf_waddr   = '0;
        rf_we      = 1'b0;
        alu_op     = '0;
        alu_func   = '0;
        rd_valid   = 1'b0;
        case (state_q)
            S_DECODE: busy = 1'b1;
            S_READ: begin
                busy       = 1'b1;
                pe_bcast   = 1'b1;
                rf_raddr_a = {5'b0, rs_q};
                rf_raddr_b = {5'b0, rt_q};
            end
            S_EXEC: begin
                busy     = 1'b1;
                pe_bcast = 1'b1;
                alu_op   = op_q;
                alu_func = func_q;
            end
            S_WRITE: begin
                busy     = 1'b1;
                pe_bcast = 1'b1;
                rf_waddr = {5'b0, rd_q};
                // Register 0 is hardwired; reset kills the write in the same cycle.
                rf_we    = (rd_q != 5'd0) && !reset;
            end
            S_DONE: begin
                done    = 1'b1;
                illegal = illegal_q;
            end
            S_HREAD: begin
                pe_sel     = hr_pe_q;
                rf_raddr_a = hr_reg_q;
            end
            S_HRESP: rd_valid = 1'b1;
            default: ;
        endcase
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_array_sequencer.sv
// tb/tb_array_sequencer.sv - directed self-checking bench for array_sequencer
module tb_array_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] instruction;
    logic        host_rd;
    logic [4:0]  pe_addr;
    logic [9:0]  reg_addr;
    logic [15:0] pe_rd_data;
    logic        busy, done, illegal, pe_bcast, rf_we, rd_valid;
    logic [4:0]  pe_sel;
    logic [9:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [5:0]  alu_op, alu_func;
    logic [15:0] rd_data;

    int total = 0;
    int bad   = 0;

    // per-sequence observations
    int first_busy, busy_cnt, bcast_cnt, we_cnt, done_cnt, done_idx, ill_cnt, ill_idx;
    int alu_cnt, sel_idx, rdv_idx, rdv_cnt;
    int waddr_at_we, raddr_a_seen, raddr_b_seen, alu_func_seen, sel_at, raddr_at_sel, rd_data_at;

    array_sequencer #(.SIZE(5), .LENGTH(32), .EX_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .instruction(instruction),
        .host_rd(host_rd), .pe_addr(pe_addr), .reg_addr(reg_addr), .pe_rd_data(pe_rd_data),
        .busy(busy), .done(done), .illegal(illegal), .pe_bcast(pe_bcast), .pe_sel(pe_sel),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr), .rf_we(rf_we),
        .alu_op(alu_op), .alu_func(alu_func), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        start   = 1'b0;
        host_rd = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Launch with start 0->1 (held high) in cycle 0; host_rd follows hr_mask per cycle.
    task automatic run_seq(input logic [31:0] instr, input logic [15:0] hr_mask,
                           input logic [4:0] pa1, input logic [9:0] ra1,
                           input logic [4:0] pa2, input logic [9:0] ra2, input int n);
        first_busy = -1; busy_cnt = 0; bcast_cnt = 0; we_cnt = 0; done_cnt = 0; done_idx = -1;
        ill_cnt = 0; ill_idx = -1; alu_cnt = 0; sel_idx = -1; rdv_idx = -1; rdv_cnt = 0;
        waddr_at_we = -1; raddr_a_seen = -1; raddr_b_seen = -1; alu_func_seen = 0;
        sel_at = -1; raddr_at_sel = -1; rd_data_at = -1;
        instruction = instr;
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            host_rd  = hr_mask[i];
            pe_addr  = (i <= 1) ? pa1 : pa2;
            reg_addr = (i <= 1) ? ra1 : ra2;
            tick();
            host_rd = 1'b0;
            if (busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = i + 1;
            end
            if (pe_bcast) begin
                if (bcast_cnt == 0) begin
                    raddr_a_seen = int'(rf_raddr_a);
                    raddr_b_seen = int'(rf_raddr_b);
                end
                bcast_cnt++;
            end
            if (rf_we) begin we_cnt++; waddr_at_we = int'(rf_waddr); end
            if (done) begin done_cnt++; done_idx = i + 1; end
            if (illegal) begin ill_cnt++; ill_idx = i + 1; end
            if (alu_func != 6'd0) begin alu_cnt++; alu_func_seen = int'(alu_func); end
            if (pe_sel != 5'd0 && sel_idx < 0) begin
                sel_idx = i + 1; sel_at = int'(pe_sel); raddr_at_sel = int'(rf_raddr_a);
            end
            if (rd_valid) begin
                rdv_cnt++;
                if (rdv_idx < 0) begin rdv_idx = i + 1; rd_data_at = int'(rd_data); end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; host_rd = 1'b0; instruction = 32'h0024_1800;
        pe_addr = '0; reg_addr = '0; pe_rd_data = '0;
        tick(); tick();
        total++;
        if ({busy, done, illegal, pe_bcast, rf_we, rd_valid} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, illegal, pe_bcast, rf_we, rd_valid});
        end
        total++;
        if ({pe_sel, rf_raddr_a, rf_raddr_b, rf_waddr, alu_op, alu_func, rd_data} !== '0) begin
            bad++; $display("FAIL reset_data: outputs not all zero (rd_data=%h raddr_a=%h)", rd_data, rf_raddr_a);
        end
        reset = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        total++;
        if (busy_cnt !== 0) begin
            bad++; $display("FAIL start_held_through_reset: busy cycles %0d want 0", busy_cnt);
        end
        idle_cycles(2);
    endtask

    task automatic test_legal;
        run_seq(32'h0024_1800, 16'h0000, 5'd0, 10'd0, 5'd0, 10'd0, 12);
        total++;
        if (first_busy !== 1 || busy_cnt !== 5) begin
            bad++; $display("FAIL legal_busy: first=%0d count=%0d want first=1 count=5", first_busy, busy_cnt);
        end
        total++;
        if (raddr_a_seen !== 1 || raddr_b_seen !== 4) begin
            bad++; $display("FAIL legal_raddr: a=%0d b=%0d want a=1 b=4", raddr_a_seen, raddr_b_seen);
        end
        total++;
        if (we_cnt !== 1 || waddr_at_we !== 3) begin
            bad++; $display("FAIL legal_write: we_cnt=%0d waddr=%0d want 1 and 3", we_cnt, waddr_at_we);
        end
        total++;
        if (done_cnt !== 1 || done_idx !== 6 || ill_cnt !== 0) begin
            bad++; $display("FAIL legal_done: cnt=%0d idx=%0d ill=%0d want 1 6 0", done_cnt, done_idx, ill_cnt);
        end
        total++;
        if (bcast_cnt !== 4) begin
            bad++; $display("FAIL legal_bcast: got %0d want 4", bcast_cnt);
        end
        idle_cycles(2);
    endtask

    task automatic test_rd_zero;
        run_seq(32'h0024_0000, 16'h0000, 5'd0, 10'd0, 5'd0, 10'd0, 10);
        total++;
        if (busy_cnt !== 5 || we_cnt !== 0 || done_cnt !== 1) begin
            bad++; $display("FAIL rd_zero: busy=%0d we=%0d done=%0d want 5 0 1", busy_cnt, we_cnt, done_cnt);
        end
        idle_cycles(2);
    endtask

    task automatic test_alu_fields;
        run_seq(32'h00A6_202A, 16'h0000, 5'd0, 10'd0, 5'd0, 10'd0, 10);
        total++;
        if (alu_cnt !== 2 || alu_func_seen !== 'h2A) begin
            bad++; $display("FAIL alu_func: cycles=%0d func=%h want 2 and 2a", alu_cnt, alu_func_seen);
        end
        total++;
        if (raddr_a_seen !== 5 || raddr_b_seen !== 6 || waddr_at_we !== 4) begin
            bad++; $display("FAIL alu_addrs: a=%0d b=%0d w=%0d want 5 6 4", raddr_a_seen, raddr_b_seen, waddr_at_we);
        end
        idle_cycles(2);
    endtask

    task automatic test_illegal;
        run_seq(32'h2000_0000, 16'h0000, 5'd0, 10'd0, 5'd0, 10'd0, 8);
        total++;
        if (first_busy !== 1 || busy_cnt !== 1) begin
            bad++; $display("FAIL illegal_busy: first=%0d count=%0d want 1 1", first_busy, busy_cnt);
        end
        total++;
        if (done_idx !== 2 || ill_idx !== 2 || ill_cnt !== 1) begin
            bad++; $display("FAIL illegal_flag: done@%0d ill@%0d cnt=%0d want 2 2 1", done_idx, ill_idx, ill_cnt);
        end
        total++;
        if (bcast_cnt !== 0 || we_cnt !== 0) begin
            bad++; $display("FAIL illegal_quiet: bcast=%0d we=%0d want 0 0", bcast_cnt, we_cnt);
        end
        idle_cycles(2);
    endtask

    task automatic test_host_read;
        pe_rd_data = 16'hBEEF;
        pe_addr = 5'h11; reg_addr = 10'h020; host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        total++;
        if (pe_sel !== 5'h11 || rf_raddr_a !== 10'h020 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL hread_sel: pe_sel=%h raddr_a=%h rd_valid=%b want 11 020 0", pe_sel, rf_raddr_a, rd_valid);
        end
        tick();
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF || pe_sel !== 5'h0) begin
            bad++; $display("FAIL hread_resp: rd_valid=%b rd_data=%h pe_sel=%h want 1 beef 00", rd_valid, rd_data, pe_sel);
        end
        pe_rd_data = 16'h0000;
        tick();
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 16'hBEEF) begin
            bad++; $display("FAIL hread_hold: rd_valid=%b rd_data=%h want 0 beef", rd_valid, rd_data);
        end
        idle_cycles(2);
    endtask

    task automatic test_read_during_busy;
        pe_rd_data = 16'h1234;
        run_seq(32'h0024_1800, 16'b0000_0000_0000_1010, 5'd3, 10'd5, 5'd7, 10'd9, 14);
        total++;
        if (done_idx !== 6 || sel_idx !== 8) begin
            bad++; $display("FAIL busy_read_order: done@%0d sel@%0d want 6 8", done_idx, sel_idx);
        end
        total++;
        if (sel_at !== 3 || raddr_at_sel !== 5) begin
            bad++; $display("FAIL busy_read_addr: pe_sel=%0d raddr_a=%0d want 3 5", sel_at, raddr_at_sel);
        end
        total++;
        if (rdv_idx !== 9 || rdv_cnt !== 1 || rd_data_at !== 'h1234) begin
            bad++; $display("FAIL busy_read_resp: rdv@%0d cnt=%0d data=%h want 9 1 1234", rdv_idx, rdv_cnt, rd_data_at);
        end
        idle_cycles(2);
    endtask

    task automatic test_same_cycle;
        pe_rd_data = 16'h5A5A;
        run_seq(32'h0024_1800, 16'b0000_0000_0000_0001, 5'h0A, 10'h00B, 5'h0A, 10'h00B, 12);
        total++;
        if (first_busy !== 1 || done_idx !== 6 || we_cnt !== 1) begin
            bad++; $display("FAIL same_cycle_instr: first=%0d done@%0d we=%0d want 1 6 1", first_busy, done_idx, we_cnt);
        end
        total++;
        if (sel_idx !== 8 || sel_at !== 'h0A || raddr_at_sel !== 'h00B) begin
            bad++; $display("FAIL same_cycle_sel: sel@%0d pe=%h reg=%h want 8 0a 00b", sel_idx, sel_at, raddr_at_sel);
        end
        total++;
        if (rdv_idx !== 9 || rdv_cnt !== 1 || rd_data_at !== 'h5A5A) begin
            bad++; $display("FAIL same_cycle_resp: rdv@%0d cnt=%0d data=%h want 9 1 5a5a", rdv_idx, rdv_cnt, rd_data_at);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_exec;
        int cnt_done, cnt_rdv, cnt_busy;
        instruction = 32'h00A6_202A;
        start = 1'b1;
        tick();
        pe_addr = 5'd2; reg_addr = 10'd2; host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        tick();
        total++;
        if (pe_bcast !== 1'b1 || alu_func !== 6'h2A) begin
            bad++; $display("FAIL pre_reset_exec: pe_bcast=%b alu_func=%h want 1 2a", pe_bcast, alu_func);
        end
        reset = 1'b1;
        tick();
        total++;
        if ({busy, done, pe_bcast, rf_we, rd_valid, alu_op, alu_func, pe_sel, rf_raddr_a, rf_raddr_b, rf_waddr, rd_data} !== '0) begin
            bad++; $display("FAIL reset_abort: busy=%b bcast=%b alu_func=%h rd_data=%h want all zero", busy, pe_bcast, alu_func, rd_data);
        end
        reset = 1'b0;
        cnt_done = 0; cnt_rdv = 0; cnt_busy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) cnt_done++;
            if (rd_valid) cnt_rdv++;
            if (busy) cnt_busy++;
        end
        total++;
        if (cnt_done !== 0 || cnt_rdv !== 0 || cnt_busy !== 0) begin
            bad++; $display("FAIL post_abort: done=%0d rd_valid=%0d busy=%0d want 0 0 0", cnt_done, cnt_rdv, cnt_busy);
        end
        idle_cycles(2);
    endtask

    initial begin
        test_reset();
        test_legal();
        test_rd_zero();
        test_alu_fields();
        test_illegal();
        test_host_read();
        test_read_during_busy();
        test_same_cycle();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
